uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage with 16x-style oversampling, start-bit validation and stop-bit checking.
- Holds each received word until the consumer reads it.
- Its Data_Rdy_Out, Rx_Data_Out and RTS outputs feed both the receive FIFO path and the BIST controller.
- In BIST mode, Rx_Serial is looped back from the transmitter by top-level muxing, not by this block.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_receiver.sv | 194 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive path.
// Build with UART_RX_PARITY_EN defined to add the PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    // Tick index at which a bit is sampled, counted from its leading edge.
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick prescaler: one-cycle tick every BAUD_DIV clocks, with a
// synchronous restart so frame timing is anchored to the detected start edge.
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic Clk,
    input  logic Rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with start validation, stop check and overrun flag.
// Optional parity (state PARITY, Parity_Odd/Parity_Error) via UART_RX_PARITY_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 27
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx_Serial,
    input  logic                 Rx_Read,
`ifdef UART_RX_PARITY_EN
    input  logic                 Parity_Odd,
    output logic                 Parity_Error,
`endif
    output logic [DATA_BITS-1:0] Rx_Data_Out,
    output logic                 Data_Rdy_Out,
    output logic                 RTS,
    output logic                 Framing_Error,
    output logic                 Overrun_Error
);

    localparam int            SW          = $clog2(OVERSAMPLE);
    localparam int            BW          = $clog2(DATA_BITS);
    localparam logic [SW-1:0] MID_SAMPLE  = SW'(mid_tick(OVERSAMPLE));
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 start_edge;
    logic                 tick;
    rx_state_t            state;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit;
`endif

    // Synchronizer resets to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta <= ON;
            rx_sync <= ON;
            rx_prev <= ON;
        end else begin
            rx_meta <= Rx_Serial;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == IDLE) && rx_prev && !rx_sync;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .Clk     (Clk),
        .Rst     (Rst),
        .restart (start_edge),
        .tick    (tick)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            Rx_Data_Out   <= '0;
            Data_Rdy_Out  <= OFF;
            RTS           <= ON;
            Framing_Error <= OFF;
            Overrun_Error <= OFF;
`ifdef UART_RX_PARITY_EN
            parity_bit    <= OFF;
            Parity_Error  <= OFF;
`endif
        end else begin
            Overrun_Error <= OFF;

            // A completing word later in this block overrides the read clear.
            if (Rx_Read && Data_Rdy_Out) begin
                Data_Rdy_Out  <= OFF;
                Framing_Error <= OFF;
`ifdef UART_RX_PARITY_EN
                Parity_Error  <= OFF;
`endif
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state      <= START;
                        RTS        <= OFF;
                        sample_cnt <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (sample_cnt == MID_SAMPLE) begin
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            if (rx_sync) begin
                                state <= IDLE;
                                RTS   <= ON;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            shift_reg  <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            parity_bit <= rx_sync;
                            state      <= STOP;
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt    <= '0;
                            Rx_Data_Out   <= shift_reg;
                            Data_Rdy_Out  <= ON;
                            Framing_Error <= !rx_sync;
                            Overrun_Error <= Data_Rdy_Out && !Rx_Read;
`ifdef UART_RX_PARITY_EN
                            Parity_Error  <= (^shift_reg) ^ parity_bit ^ Parity_Odd;
`endif
                            // A low stop bit may be a break; hold off until the line recovers.
                            if (rx_sync) begin
                                state <= IDLE;
                                RTS   <= ON;
                            end else begin
                                state <= WAIT_HIGH;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end

                WAIT_HIGH: begin
                    if (rx_sync) begin
                        state <= IDLE;
                        RTS   <= ON;
                    end
                end

                default: begin
                    state <= IDLE;
                    RTS   <= ON;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: vector table, corner sequences and
// randomized frames against a frame-level reference model.
module tb_uart_receiver;

    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int BD  = 4;
    localparam int BIT = OS * BD;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_BITS = 2 + DB + PBITS;
    localparam int LATENCY    = (OS * (DB + 1 + PBITS) + OS / 2) * BD + 3;

    logic          clk;
    logic          rst;
    logic          rxSerial;
    logic          rxRead;
    logic [DB-1:0] rxData;
    logic          dataRdy;
    logic          rts;
    logic          framingError;
    logic          overrunError;
`ifdef UART_RX_PARITY_EN
    logic          parityOdd;
    logic          parityError;
`endif

    int compared;
    int mismatched;

    uart_receiver #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .BAUD_DIV   (BD)
    ) dut (
        .Clk           (clk),
        .Rst           (rst),
        .Rx_Serial     (rxSerial),
        .Rx_Read       (rxRead),
`ifdef UART_RX_PARITY_EN
        .Parity_Odd    (parityOdd),
        .Parity_Error  (parityError),
`endif
        .Rx_Data_Out   (rxData),
        .Data_Rdy_Out  (dataRdy),
        .RTS           (rts),
        .Framing_Error (framingError),
        .Overrun_Error (overrunError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseRead();
        @(posedge clk);
        #1;
        rxRead = 1'b1;
        @(posedge clk);
        #1;
        rxRead = 1'b0;
    endtask

    // Cycle c is observed/driven #1 after the c-th posedge; the start bit is driven at c = 0.
    task automatic applyStimulus(input logic [DB-1:0] data, input logic stopBit, input logic parBit,
                                 input int readAt, input int resetAt,
                                 output int rdyRise, output int ovrCycles,
                                 output logic rtsMid, output logic [DB+3:0] snap);
        logic [FRAME_BITS-1:0] bits;
        logic                  prevRdy;
        bits = '0;
        for (int i = 0; i < DB; i++) bits[1 + i] = data[i];
        if (PBITS == 1) bits[DB + 1] = parBit;
        bits[FRAME_BITS - 1] = stopBit;
        rdyRise   = -1;
        ovrCycles = 0;
        rtsMid    = 1'b1;
        snap      = '0;
        prevRdy   = dataRdy;
        for (int c = 0; c < FRAME_BITS * BIT; c++) begin
            @(posedge clk);
            #1;
            if (dataRdy && !prevRdy && rdyRise < 0) rdyRise = c;
            prevRdy = dataRdy;
            if (overrunError) ovrCycles++;
            if (c == BIT * 5) rtsMid = rts;
            if (c == resetAt + 1) snap = {rxData, dataRdy, rts, framingError, overrunError};
            rst      = (resetAt >= 0 && c >= resetAt && c < resetAt + 3);
            rxRead   = (c == readAt);
            rxSerial = bits[c / BIT];
        end
        rxSerial = 1'b1;
        rxRead   = 1'b0;
        rst      = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (overrunError) ovrCycles++;
        end
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          stopBit;
        logic [DB-1:0] expData;
        logic          expFe;
    } vec_t;

    vec_t           vecs[4];
    int             rise;
    int             ovr;
    logic           rtsM;
    logic [DB+3:0]  snap;
    logic           pending;
    logic [DB-1:0]  rndData;
    logic           rndStop;
    logic           rndPar;
    logic           rndRead;
    logic           glRts10;
    logic           glRts40;
    logic           glRdy;
    logic           brkRts;
    int             brkRises;
    logic           prevRdy;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        rxSerial   = 1'b1;
        rxRead     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityOdd  = 1'b0;
`endif
        idle(3);
        rst = 1'b0;
        idle(4);

        checkOutput("reset data", 32'(rxData), 32'h0);
        checkOutput("reset rdy", 32'(dataRdy), 32'h0);
        checkOutput("reset rts", 32'(rts), 32'h1);
        checkOutput("reset fe", 32'(framingError), 32'h0);
        checkOutput("reset ovr", 32'(overrunError), 32'h0);

        vecs[0] = '{data: 8'hAA, stopBit: 1'b1, expData: 8'hAA, expFe: 1'b0};
        vecs[1] = '{data: 8'h00, stopBit: 1'b1, expData: 8'h00, expFe: 1'b0};
        vecs[2] = '{data: 8'hFF, stopBit: 1'b1, expData: 8'hFF, expFe: 1'b0};
        vecs[3] = '{data: 8'h5A, stopBit: 1'b0, expData: 8'h5A, expFe: 1'b1};

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].data, vecs[v].stopBit, ^vecs[v].data, -1, -1, rise, ovr, rtsM, snap);
            checkOutput("vec latency", 32'(rise), 32'(LATENCY));
            checkOutput("vec data", 32'(rxData), 32'(vecs[v].expData));
            checkOutput("vec fe", 32'(framingError), 32'(vecs[v].expFe));
            checkOutput("vec rts mid", 32'(rtsM), 32'h0);
            checkOutput("vec rts after", 32'(rts), 32'h1);
            checkOutput("vec ovr", 32'(ovr), 32'h0);
`ifdef UART_RX_PARITY_EN
            checkOutput("vec pe", 32'(parityError), 32'h0);
`endif
            pulseRead();
            checkOutput("vec read rdy", 32'(dataRdy), 32'h0);
            checkOutput("vec read fe", 32'(framingError), 32'h0);
            idle(4);
        end

        // Short low glitch must be rejected at the start mid-sample.
        glRdy = 1'b0;
        glRts10 = 1'b1;
        glRts40 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) glRts10 = rts;
            if (c == 40) glRts40 = rts;
            if (dataRdy) glRdy = 1'b1;
            rxSerial = (c < 20) ? 1'b0 : 1'b1;
        end
        checkOutput("glitch rts low", 32'(glRts10), 32'h0);
        checkOutput("glitch rts back", 32'(glRts40), 32'h1);
        checkOutput("glitch rdy", 32'(glRdy), 32'h0);

        // Break: twelve bit times low, then recovery and a clean frame.
        rise = -1;
        ovr = 0;
        brkRises = 0;
        brkRts = 1'b1;
        prevRdy = dataRdy;
        for (int c = 0; c < 12 * BIT + 100; c++) begin
            @(posedge clk);
            #1;
            if (dataRdy && !prevRdy) begin
                brkRises++;
                if (rise < 0) rise = c;
            end
            prevRdy = dataRdy;
            if (overrunError) ovr++;
            if (c == 11 * BIT) brkRts = rts;
            rxSerial = (c < 12 * BIT) ? 1'b0 : 1'b1;
        end
        checkOutput("break latency", 32'(rise), 32'(LATENCY));
        checkOutput("break rises", 32'(brkRises), 32'h1);
        checkOutput("break data", 32'(rxData), 32'h0);
        checkOutput("break fe", 32'(framingError), 32'h1);
        checkOutput("break ovr", 32'(ovr), 32'h0);
        checkOutput("break rts held", 32'(brkRts), 32'h0);
        checkOutput("break rts after", 32'(rts), 32'h1);
        pulseRead();
        applyStimulus(8'h55, 1'b1, ^(8'h55), -1, -1, rise, ovr, rtsM, snap);
        checkOutput("post-break latency", 32'(rise), 32'(LATENCY));
        checkOutput("post-break data", 32'(rxData), 32'h55);
        checkOutput("post-break fe", 32'(framingError), 32'h0);
        pulseRead();

        // Overrun: two words without a read, then again with a coincident read.
        applyStimulus(8'h12, 1'b1, ^(8'h12), -1, -1, rise, ovr, rtsM, snap);
        applyStimulus(8'h34, 1'b1, ^(8'h34), -1, -1, rise, ovr, rtsM, snap);
        checkOutput("overrun pulses", 32'(ovr), 32'h1);
        checkOutput("overrun data", 32'(rxData), 32'h34);
        checkOutput("overrun rdy", 32'(dataRdy), 32'h1);
        pulseRead();
        applyStimulus(8'h12, 1'b1, ^(8'h12), -1, -1, rise, ovr, rtsM, snap);
        applyStimulus(8'h34, 1'b1, ^(8'h34), LATENCY - 1, -1, rise, ovr, rtsM, snap);
        checkOutput("coincident ovr", 32'(ovr), 32'h0);
        checkOutput("coincident rdy", 32'(dataRdy), 32'h1);
        checkOutput("coincident data", 32'(rxData), 32'h34);

        // Reset during data bit 4 with an unread word held.
        applyStimulus(8'hFF, 1'b1, ^(8'hFF), -1, 5 * BIT + 10, rise, ovr, rtsM, snap);
        checkOutput("reset mid-frame outputs", 32'(snap), 32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
        checkOutput("reset mid-frame no word", 32'(rise), 32'hFFFFFFFF);
        checkOutput("reset mid-frame rdy", 32'(dataRdy), 32'h0);
        applyStimulus(8'h3C, 1'b1, ^(8'h3C), -1, -1, rise, ovr, rtsM, snap);
        checkOutput("post-reset latency", 32'(rise), 32'(LATENCY));
        checkOutput("post-reset data", 32'(rxData), 32'h3C);
        pulseRead();

`ifdef UART_RX_PARITY_EN
        parityOdd = 1'b0;
        applyStimulus(8'h07, 1'b1, 1'b1, -1, -1, rise, ovr, rtsM, snap);
        checkOutput("parity good pe", 32'(parityError), 32'h0);
        pulseRead();
        applyStimulus(8'h07, 1'b1, 1'b0, -1, -1, rise, ovr, rtsM, snap);
        checkOutput("parity bad pe", 32'(parityError), 32'h1);
        checkOutput("parity latency", 32'(rise), 32'd675);
        pulseRead();
        checkOutput("parity read pe", 32'(parityError), 32'h0);
`endif

        // Random frames against a word-level model: data, stop level, unread-word tracking.
        pending = 1'b0;
        for (int n = 0; n < 24; n++) begin
            rndData = DB'($urandom);
            rndStop = ($urandom_range(0, 3) != 0);
            rndPar  = 1'($urandom_range(0, 1));
            rndRead = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
            parityOdd = 1'($urandom_range(0, 1));
`endif
            applyStimulus(rndData, rndStop, rndPar, -1, -1, rise, ovr, rtsM, snap);
            checkOutput("rnd data", 32'(rxData), 32'(rndData));
            checkOutput("rnd fe", 32'(framingError), rndStop ? 32'h0 : 32'h1);
            checkOutput("rnd ovr", 32'(ovr), pending ? 32'h1 : 32'h0);
            checkOutput("rnd rdy", 32'(dataRdy), 32'h1);
            if (!pending) checkOutput("rnd latency", 32'(rise), 32'(LATENCY));
`ifdef UART_RX_PARITY_EN
            checkOutput("rnd pe", 32'(parityError),
                        32'((($countones(rndData) + int'(rndPar)) % 2) != int'(parityOdd)));
`endif
            pending = 1'b1;
            if (rndRead) begin
                pulseRead();
                pending = 1'b0;
                checkOutput("rnd read rdy", 32'(dataRdy), 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
